// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
// Streams a host-supplied configuration bitstream, MSB-first, into a CCFF
// shift chain and drives the chain's shift-enable.
// Optional macro CCFF_CHAIN_LOADER_VERIFY_EN adds a second pass that re-sends
// the bitstream and compares ccff_tail against ccff_head; any difference sets
// a sticky mismatch flag. Without the macro the loader runs a single pass
// and mismatch is tied low.
//
// Handshake: a word moves from host to loader on a prog_clk rising edge where
// word_valid and word_ready are both 1. word_ready is high only in FETCH, and
// word_valid is ignored in every other state.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 36,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              mismatch,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CHAIN_LEN);
    localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [WORD_W-1:0] r_sr;
    logic              r_head;
    logic              r_shift_en;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WB_W-1:0]   r_word_bit;

    logic w_accept;
    logic w_last_bit;
    logic w_pass_end;
    logic w_first_pass_end;

    // A word is taken only in FETCH; the shift ends on the word's last bit or
    // on the chain's last bit, whichever comes first (partial last word).
    assign w_accept   = (r_state == S_FETCH) && word_valid;
    assign w_pass_end = (r_bit_cnt == CNT_LAST);
    assign w_last_bit = (r_word_bit == WB_LAST) || w_pass_end;

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    logic r_pass2;
    logic r_mismatch;
    assign w_first_pass_end = (r_state == S_SHIFT) && w_pass_end && !r_pass2;
`else
    assign w_first_pass_end = 1'b0;
`endif

    // Next-state decode for the IDLE/FETCH/SHIFT/DONE sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (w_last_bit) begin
                    if (!w_pass_end)           w_state_nxt = S_FETCH;
                    else if (w_first_pass_end) w_state_nxt = S_FETCH;
                    else                       w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    // Shift register, serial outputs and bit counters. ccff_head and
    // ccff_shift_en are loaded on the edge that enters each SHIFT cycle so
    // they are registered yet line up with the SHIFT state.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_sr       <= '0;
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            r_bit_cnt  <= '0;
            r_word_bit <= '0;
        end else begin
            r_head     <= 1'b0;
            r_shift_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bit_cnt  <= '0;
                        r_word_bit <= '0;
                    end
                end
                S_FETCH: begin
                    if (w_accept) begin
                        r_sr       <= word_in << 1;
                        r_head     <= word_in[WORD_W-1];
                        r_shift_en <= 1'b1;
                        r_word_bit <= '0;
                    end
                end
                S_SHIFT: begin
                    if (w_first_pass_end)
                        r_bit_cnt <= '0;
                    else if (r_bit_cnt != CNT_MAX)
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    if (w_last_bit) begin
                        r_word_bit <= '0;
                    end else begin
                        r_head     <= r_sr[WORD_W-1];
                        r_sr       <= r_sr << 1;
                        r_shift_en <= 1'b1;
                        r_word_bit <= r_word_bit + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
    // Pass tracking and sticky tail-vs-head compare during the second pass.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_pass2    <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_pass2    <= 1'b0;
                r_mismatch <= 1'b0;
            end
            if (r_state == S_SHIFT && r_pass2 && (ccff_tail != r_head))
                r_mismatch <= 1'b1;
            if (w_first_pass_end && w_last_bit)
                r_pass2 <= 1'b1;
        end
    end
    assign mismatch = r_mismatch;
`else
    logic w_unused_tail;
    assign w_unused_tail = ccff_tail;
    assign mismatch      = 1'b0;
`endif

    assign word_ready    = (r_state == S_FETCH);
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_DONE);
    assign ccff_head     = r_head;
    assign ccff_shift_en = r_shift_en;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a table of load scenarios on a 36-bit chain
// (words, host stalls, stray start pulses, stuck chain bit), a reset-in-the-
// middle sequence, and a one-word load on an 8-bit chain.
module tb_ccff_chain_loader;

`ifdef CCFF_CHAIN_LOADER_VERIFY_EN
  localparam int P      = 2;
  localparam bit VERIFY = 1'b1;
`else
  localparam int P      = 1;
  localparam bit VERIFY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic prog_clk = 1'b0;
  logic pReset_n = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // ---------------- 36-bit DUT ----------------
  logic       start = 1'b0;
  logic [7:0] word_in = '0;
  logic       word_valid = 1'b0;
  logic       word_ready, ccff_head, ccff_shift_en, ccff_tail;
  logic       busy, done, mismatch;
  logic [1:0] dbg_state;

  ccff_chain_loader #(.CHAIN_LEN(36), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .mismatch(mismatch), .dbg_state(dbg_state)
  );

  // behavioral chain, optional bit 17 stuck at 1
  logic [35:0] chain = '0;
  logic [35:0] chain_eff;
  bit          stuck_en = 1'b0;
  assign chain_eff = chain | (stuck_en ? (36'h1 << 17) : 36'h0);
  assign ccff_tail = chain_eff[35];
  always @(posedge prog_clk) if (ccff_shift_en) chain <= {chain_eff[34:0], ccff_head};

  // ---------------- 8-bit DUT ----------------
  logic       b_start = 1'b0;
  logic [7:0] b_word_in = '0;
  logic       b_word_valid = 1'b0;
  logic       b_word_ready, b_head, b_shift_en, b_tail, b_busy, b_done, b_mismatch;
  logic [1:0] b_dbg_state;
  logic [7:0] chain8 = '0;
  assign b_tail = chain8[7];
  always @(posedge prog_clk) if (b_shift_en) chain8 <= {chain8[6:0], b_head};

  ccff_chain_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut8 (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(b_start),
    .word_in(b_word_in), .word_valid(b_word_valid), .word_ready(b_word_ready),
    .ccff_head(b_head), .ccff_shift_en(b_shift_en), .ccff_tail(b_tail),
    .busy(b_busy), .done(b_done), .mismatch(b_mismatch), .dbg_state(b_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_mis = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [39:0] words;     // five 8-bit words, first word in the top byte
    int          stall_idx; // word index the host stalls before (-1 none)
    int          stall_len; // FETCH cycles with word_valid low
    int          start_k;   // cycle for a stray start pulse (-1 none)
    bit          stuck;     // chain bit 17 stuck at 1
    logic        exp_mis;
    int          exp_k;     // cycles from first FETCH to done
  } vec_t;

  function automatic vec_t mk(input logic [39:0] w, input int si, input int sl,
                              input int sk, input bit st);
    vec_t v;
    v.words = w; v.stall_idx = si; v.stall_len = sl; v.start_k = sk; v.stuck = st;
    v.exp_mis = VERIFY && st;
    v.exp_k = 41 * P + sl;
    return v;
  endfunction

  // ---------------- host driver / monitor ----------------
  logic [39:0] cur_words;
  int ptr, total_words, stall_idx, stall_rem, n_shift;

  task automatic monitor();
    logic [0:0] e;
    if (ccff_shift_en) begin
      n_shift++;
      if (exp_q.size() == 0) chk("extra_shift", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("head_bit", ccff_head, e);
      end
    end
  endtask

  task automatic host_step();
    bit stall;
    int j, nb;
    stall = (ptr == stall_idx) && (stall_rem > 0) && word_ready;
    if (stall) begin
      stall_rem--;
      word_valid = 1'b0;
      word_in = 8'($urandom);
      chk("stall_no_shift", ccff_shift_en, 0);
    end else if (ptr < total_words) begin
      word_valid = 1'b1;
      word_in = cur_words[39 - 8*(ptr % 5) -: 8];
    end else begin
      word_valid = 1'b0;
      word_in = 8'($urandom);
    end
    if (word_valid && word_ready) begin
      j = ptr % 5;
      nb = (36 - 8*j < 8) ? 36 - 8*j : 8;
      for (int b = 0; b < nb; b++) exp_q.push_back(cur_words[39 - 8*j - b]);
      ptr++;
    end
  endtask

  task automatic setup(input vec_t v);
    cur_words = v.words; ptr = 0; total_words = 5 * P;
    stall_idx = v.stall_idx; stall_rem = v.stall_len; n_shift = 0;
    exp_q.delete(); stuck_en = v.stuck;
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    setup(v);
    @(negedge prog_clk); start = 1'b1;
    @(negedge prog_clk); start = 1'b0; k = 0;
    chk("first_fetch_busy", busy, 1);
    chk("first_fetch_ready", word_ready, 1);
    chk("mismatch_cleared", mismatch, 0);
    forever begin
      start = (k == v.start_k);
      monitor();
      if (done) break;
      if (k > 600) begin chk("done_timeout", 0, 1); break; end
      host_step();
      @(negedge prog_clk); k++;
    end
    start = 1'b0;
    chk("done_cycle", k, v.exp_k);
    chk("shift_count", n_shift, 36 * P);
    chk("queue_empty", exp_q.size(), 0);
    chk("mismatch_at_done", mismatch, v.exp_mis);
    if (!v.stuck) chk("chain_contents", chain, v.words[39:4]);
    word_valid = 1'b0;
    @(negedge prog_clk);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_ready", word_ready, 0);
    @(negedge prog_clk);
    chk("mismatch_sticky", mismatch, v.exp_mis);
  endtask

  // ---------------- test sequence ----------------
  vec_t vecs[6];
  int   k8, nb8;
  logic [7:0] got8;

  initial begin
    vecs[0] = mk(40'hA53CFF0093, -1, 0, -1, 1'b0);
    vecs[1] = mk(40'hA53CFF0093,  2, 3, -1, 1'b0);
    vecs[2] = mk({$urandom, 8'($urandom)}, -1, 0, 10, 1'b0);
    vecs[3] = mk(40'h0, -1, 0, -1, 1'b1);
    vecs[4] = mk(40'hFFFFFFFFFF, 4, 5, -1, 1'b0);
    vecs[5] = mk({$urandom, 8'($urandom)}, 0, 2, 20, 1'b0);

    // reset values
    repeat (3) @(negedge prog_clk);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_head", ccff_head, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_b_busy", b_busy, 0);
    pReset_n = 1'b1;
    @(negedge prog_clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // reset asserted during the second word's SHIFT
    begin
      int k;
      setup(vecs[0]);
      @(negedge prog_clk); start = 1'b1;
      @(negedge prog_clk); start = 1'b0; k = 0;
      while (!(ptr == 2 && n_shift >= 11) && k < 200) begin
        monitor();
        host_step();
        @(negedge prog_clk); k++;
      end
      chk("pre_reset_reached", k < 200, 1);
      chk("pre_reset_shift_en", ccff_shift_en, 1);
      pReset_n = 1'b0;
      #1;
      chk("midrst_word_ready", word_ready, 0);
      chk("midrst_head", ccff_head, 0);
      chk("midrst_shift_en", ccff_shift_en, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_mismatch", mismatch, 0);
      word_valid = 1'b0;
      @(negedge prog_clk);
      @(negedge prog_clk); pReset_n = 1'b1;
      @(negedge prog_clk);
      run_vec(vecs[0]);
    end

    // one-word chain: CHAIN_LEN=8, WORD_W=8
    @(negedge prog_clk); b_start = 1'b1;
    @(negedge prog_clk); b_start = 1'b0;
    b_word_valid = 1'b1; b_word_in = 8'h5A;
    k8 = 0; nb8 = 0; got8 = '0;
    chk("b_first_fetch_ready", b_word_ready, 1);
    forever begin
      if (b_shift_en) begin got8 = {got8[6:0], b_head}; nb8++; end
      if (b_done) break;
      if (k8 > 100) begin chk("b_done_timeout", 0, 1); break; end
      @(negedge prog_clk); k8++;
    end
    b_word_valid = 1'b0;
    chk("b_done_cycle", k8, 9 * P);
    chk("b_shift_count", nb8, 8 * P);
    chk("b_stream", got8, 8'h5A);
    chk("b_chain", chain8, 8'h5A);
    chk("b_mismatch", b_mismatch, 0);
    @(negedge prog_clk);
    chk("b_idle_busy", b_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
